// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the instruction/data RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned RAM_ADDR_W = 14;
  localparam int unsigned RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_WRITE
  } state_t;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } port_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Fetch port, load/store port and RAM-side signals of the arbiter.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              ram_wen;
  logic              ram_ren;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata
  );

  // Core ports plus RAM, as seen from outside the arbiter
  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata
  );

endinterface

// File: rtl/ram_byte_merge.sv
// Byte-lane merge: lanes with be set take the new word, others keep the old word.
module ram_byte_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   merged_o
);

  localparam int unsigned BE_W = DATA_W / 8;

  always_comb begin
    merged_o = old_i;
    for (int unsigned k = 0; k < BE_W; k++) begin
      if (be_i[k]) merged_o[8*k +: 8] = new_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one word RAM between fetch and load/store ports; alternating priority
// on contention, partial stores done as read-modify-write.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_t            state_q, state_d;
  port_t             last_win_q, last_win_d;
  port_t             rd_port_q, rd_port_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [BE_W-1:0]   rmw_be_q, rmw_be_d;
  logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              fetch_win;
  logic              data_win;
  logic              d_load;
  logic              d_full;
  logic              d_part;
  logic              contend;
  logic [DATA_W-1:0] merged;

  ram_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_i    (bus.ram_rdata),
    .new_i    (rmw_wdata_q),
    .be_i     (rmw_be_q),
    .merged_o (merged)
  );

  // Grant decision: only in IDLE and never while reset is asserted
  always_comb begin
    contend   = 1'b0;
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (!rst && state_q == IDLE) begin
      contend   = bus.i_req && bus.d_req;
      fetch_win = bus.i_req && (!bus.d_req || last_win_q == PORT_DATA);
      data_win  = bus.d_req && !fetch_win;
    end
    d_load = data_win && !bus.d_we;
    d_full = data_win && bus.d_we && (&bus.d_be);
    d_part = data_win && bus.d_we && (|bus.d_be) && !(&bus.d_be);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_win || d_load) state_d = RD_WAIT;
        else if (d_part)         state_d = RMW_WRITE;
      end
      RD_WAIT:   state_d = IDLE;
      RMW_WRITE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // RAM control, grants and read returns; everything forced low in reset
  always_comb begin
    bus.i_gnt     = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.d_rdata   = '0;
    bus.ram_wen   = 1'b0;
    bus.ram_ren   = 1'b0;
    bus.ram_waddr = '0;
    bus.ram_raddr = '0;
    bus.ram_wdata = '0;
    if (!rst) begin
      bus.i_rdata = i_rdata_q;
      bus.d_rdata = d_rdata_q;
      case (state_q)
        IDLE: begin
          bus.i_gnt = fetch_win;
          bus.d_gnt = data_win;
          if (fetch_win) begin
            bus.ram_ren   = 1'b1;
            bus.ram_raddr = bus.i_addr;
          end else if (d_load || d_part) begin
            bus.ram_ren   = 1'b1;
            bus.ram_raddr = bus.d_addr;
          end
          if (d_full) begin
            bus.ram_wen   = 1'b1;
            bus.ram_waddr = bus.d_addr;
            bus.ram_wdata = bus.d_wdata;
          end
        end
        RD_WAIT: begin
          if (rd_port_q == PORT_FETCH) begin
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = bus.ram_rdata;
          end else begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = bus.ram_rdata;
          end
        end
        RMW_WRITE: begin
          bus.ram_wen   = 1'b1;
          bus.ram_waddr = rmw_addr_q;
          bus.ram_wdata = merged;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    last_win_d  = last_win_q;
    rd_port_d   = rd_port_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_be_d    = rmw_be_q;
    rmw_wdata_d = rmw_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (contend) last_win_d = fetch_win ? PORT_FETCH : PORT_DATA;
    if (fetch_win)   rd_port_d = PORT_FETCH;
    else if (d_load) rd_port_d = PORT_DATA;
    if (d_part) begin
      rmw_addr_d  = bus.d_addr;
      rmw_be_d    = bus.d_be;
      rmw_wdata_d = bus.d_wdata;
    end
    if (bus.i_rvalid) i_rdata_d = bus.ram_rdata;
    if (bus.d_rvalid) d_rdata_d = bus.ram_rdata;
  end

  // First contention after reset must go to fetch, hence last_win resets to DATA
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win_q  <= PORT_DATA;
      rd_port_q   <= PORT_FETCH;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      last_win_q  <= last_win_d;
      rd_port_q   <= rd_port_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-read RAM.
module tb_ram_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model with a backdoor write port for preloading
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ram_rdata_q = '0;
  logic          bd_we   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  assign bus.ram_rdata = ram_rdata_q;

  always @(posedge clk) begin
    if (bus.ram_ren) ram_rdata_q <= mem[bus.ram_raddr];
    if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bd_we)       mem[bd_addr] <= bd_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset with requests pending: nothing may leak out
    cyc(); bd_we = 1'b1; bd_addr = 14'd5; bd_data = 32'hDEADBEEF;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    settle();
    check_eq("rst_i_gnt",   32'(bus.i_gnt),   32'd0);
    check_eq("rst_d_gnt",   32'(bus.d_gnt),   32'd0);
    check_eq("rst_ram_ren", 32'(bus.ram_ren), 32'd0);
    check_eq("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
    cyc(); bd_addr = 14'd2; bd_data = 32'h11223344;
    cyc(); bd_addr = 14'd3; bd_data = 32'h55667788;
    cyc(); bd_we = 1'b0; rst = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    settle();
    check_eq("idle_i_gnt", 32'(bus.i_gnt),   32'd0);
    check_eq("idle_i_rd",  bus.i_rdata,      32'd0);

    // Fetch only
    cyc(); bus.i_req = 1'b1; bus.i_addr = 14'd5;
    settle();
    check_eq("f_i_gnt",   32'(bus.i_gnt),     32'd1);
    check_eq("f_d_gnt",   32'(bus.d_gnt),     32'd0);
    check_eq("f_ren",     32'(bus.ram_ren),   32'd1);
    check_eq("f_raddr",   32'(bus.ram_raddr), 32'd5);
    cyc(); bus.i_req = 1'b0;
    settle();
    check_eq("f_rvalid",  32'(bus.i_rvalid),  32'd1);
    check_eq("f_rdata",   bus.i_rdata,        32'hDEADBEEF);
    check_eq("f_drvalid", 32'(bus.d_rvalid),  32'd0);
    cyc();
    settle();
    check_eq("f_rv_low",  32'(bus.i_rvalid),  32'd0);
    check_eq("f_hold",    bus.i_rdata,        32'hDEADBEEF);

    // Full store then load back
    cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b1111;
    bus.d_addr = 14'd1; bus.d_wdata = 32'd256;
    settle();
    check_eq("fs_gnt",    32'(bus.d_gnt),     32'd1);
    check_eq("fs_wen",    32'(bus.ram_wen),   32'd1);
    check_eq("fs_waddr",  32'(bus.ram_waddr), 32'd1);
    check_eq("fs_wdata",  bus.ram_wdata,      32'd256);
    check_eq("fs_ren",    32'(bus.ram_ren),   32'd0);
    cyc(); bus.d_we = 1'b0;
    settle();
    check_eq("ld_gnt",    32'(bus.d_gnt),     32'd1);
    check_eq("ld_raddr",  32'(bus.ram_raddr), 32'd1);
    cyc(); bus.d_req = 1'b0;
    settle();
    check_eq("ld_rvalid", 32'(bus.d_rvalid),  32'd1);
    check_eq("ld_rdata",  bus.d_rdata,        32'd256);
    check_eq("ld_irv",    32'(bus.i_rvalid),  32'd0);

    // Partial store, with a fetch to the same word arriving during the write
    cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0101;
    bus.d_addr = 14'd2; bus.d_wdata = 32'hAABBCCDD;
    settle();
    check_eq("ps_gnt",    32'(bus.d_gnt),     32'd1);
    check_eq("ps_ren",    32'(bus.ram_ren),   32'd1);
    check_eq("ps_raddr",  32'(bus.ram_raddr), 32'd2);
    check_eq("ps_wen0",   32'(bus.ram_wen),   32'd0);
    cyc(); bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 14'd2;
    settle();
    check_eq("ps_nogrant", 32'(bus.i_gnt),    32'd0);
    check_eq("ps_wen",    32'(bus.ram_wen),   32'd1);
    check_eq("ps_waddr",  32'(bus.ram_waddr), 32'd2);
    check_eq("ps_wdata",  bus.ram_wdata,      32'h11BB33DD);
    check_eq("ps_ren1",   32'(bus.ram_ren),   32'd0);
    check_eq("ps_drv",    32'(bus.d_rvalid),  32'd0);
    cyc();
    settle();
    check_eq("ps_mem",    mem[2],             32'h11BB33DD);
    check_eq("ps_fgnt",   32'(bus.i_gnt),     32'd1);
    cyc(); bus.i_req = 1'b0;
    settle();
    check_eq("ps_frdata", bus.i_rdata,        32'h11BB33DD);

    // Contention with both ports holding load requests
    cyc(); bus.i_req = 1'b1; bus.i_addr = 14'd5;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 14'd1;
    settle();
    check_eq("c0_i_gnt",  32'(bus.i_gnt),     32'd1);
    check_eq("c0_d_gnt",  32'(bus.d_gnt),     32'd0);
    check_eq("c0_raddr",  32'(bus.ram_raddr), 32'd5);
    cyc();
    settle();
    check_eq("c1_irv",    32'(bus.i_rvalid),  32'd1);
    check_eq("c1_ird",    bus.i_rdata,        32'hDEADBEEF);
    check_eq("c1_d_gnt",  32'(bus.d_gnt),     32'd0);
    cyc();
    settle();
    check_eq("c2_d_gnt",  32'(bus.d_gnt),     32'd1);
    check_eq("c2_i_gnt",  32'(bus.i_gnt),     32'd0);
    check_eq("c2_raddr",  32'(bus.ram_raddr), 32'd1);
    cyc();
    settle();
    check_eq("c3_drv",    32'(bus.d_rvalid),  32'd1);
    check_eq("c3_drd",    bus.d_rdata,        32'd256);
    check_eq("c3_irv",    32'(bus.i_rvalid),  32'd0);
    cyc();
    settle();
    check_eq("c4_i_gnt",  32'(bus.i_gnt),     32'd1);
    check_eq("c4_d_gnt",  32'(bus.d_gnt),     32'd0);
    cyc(); bus.i_req = 1'b0; bus.d_req = 1'b0;
    settle();
    check_eq("c5_irv",    32'(bus.i_rvalid),  32'd1);

    // Reset during RMW_WRITE drops the write
    cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0001;
    bus.d_addr = 14'd3; bus.d_wdata = 32'h000000FF;
    settle();
    check_eq("rr_gnt",    32'(bus.d_gnt),     32'd1);
    cyc(); bus.d_req = 1'b0; rst = 1'b1;
    settle();
    check_eq("rr_wen",    32'(bus.ram_wen),   32'd0);
    check_eq("rr_ren",    32'(bus.ram_ren),   32'd0);
    check_eq("rr_wdata",  bus.ram_wdata,      32'd0);
    check_eq("rr_i_rd",   bus.i_rdata,        32'd0);
    check_eq("rr_d_rd",   bus.d_rdata,        32'd0);
    cyc(); rst = 1'b0; bus.i_req = 1'b1; bus.i_addr = 14'd3;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 14'd1;
    settle();
    check_eq("rr_mem",    mem[3],             32'h55667788);
    check_eq("rr_i_gnt",  32'(bus.i_gnt),     32'd1);
    check_eq("rr_d_gnt",  32'(bus.d_gnt),     32'd0);
    cyc(); bus.i_req = 1'b0;
    settle();
    check_eq("rr_ird",    bus.i_rdata,        32'h55667788);
    cyc();
    settle();
    check_eq("rr_d_gnt2", 32'(bus.d_gnt),     32'd1);
    cyc(); bus.d_req = 1'b0;
    settle();
    check_eq("rr_drd",    bus.d_rdata,        32'd256);

    // Zero-enable store: granted with no RAM access, next request immediate
    cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0000;
    bus.d_addr = 14'd4; bus.d_wdata = 32'h12345678;
    settle();
    check_eq("z_gnt",     32'(bus.d_gnt),     32'd1);
    check_eq("z_wen",     32'(bus.ram_wen),   32'd0);
    check_eq("z_ren",     32'(bus.ram_ren),   32'd0);
    cyc(); bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 14'd5;
    settle();
    check_eq("z_i_gnt",   32'(bus.i_gnt),     32'd1);
    check_eq("z_i_ren",   32'(bus.ram_ren),   32'd1);
    cyc(); bus.i_req = 1'b0;
    settle();
    check_eq("z_irv",     32'(bus.i_rvalid),  32'd1);
    check_eq("z_ird",     bus.i_rdata,        32'hDEADBEEF);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
